instruction_fetch: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Issues instruction-memory reads at the current PC and advances the PC by pulsing its count input on each accepted request.
- Tracks in-flight reads, buffers returned instructions with their PCs in a small in-order FIFO, and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump load of the PC) by flushing buffered and in-flight fetches.

---
 rtl/instruction_fetch.sv | 198 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage between program counter and decode
//
// Issues instruction-memory reads at the current PC, tracks in-flight reads,
// buffers returned instructions with their PCs in an in-order FIFO and hands
// them to decode over a valid/ready handshake. A redirect (flush) empties the
// FIFO and marks every in-flight read to be dropped on return.
//
// Optional feature macro: INSTRUCTION_FETCH_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty is presented to
//   decode in the same cycle (zero-cycle latency). When undefined, the output
//   is taken from the FIFO only (one-cycle latency).
//
// Parameters:
//   MAX_OUTSTANDING  accepted reads awaiting a response (1..4)
//   FIFO_DEPTH       instruction/PC buffer entries (2..4), also bounds
//                    outstanding + buffered
//
// Ports:
//   clk            clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   pc             current PC from the program counter
//   pc_count       advance PC by 4 (request accepted this cycle)
//   flush          redirect this cycle
//   mem_req_valid  read request valid
//   mem_req_ready  memory accepts request
//   mem_req_addr   read address (pc passed through)
//   mem_rsp_valid  read data valid, in request order
//   mem_rsp_data   instruction word
//   out_valid      instruction available to decode
//   out_ready      decode accepts
//   out_instr      instruction word
//   out_pc         address the instruction was fetched from

module instruction_fetch #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    output logic        pc_count,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;

    logic [31:0]   aq_mem [MAX_OUTSTANDING];
    logic [AW-1:0] aq_wr;
    logic [AW-1:0] aq_rd;
    logic [31:0]   aq_head;

    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [FW-1:0] f_wr;
    logic [FW-1:0] f_rd;
    logic [CW-1:0] fifo_count;

    logic credit_ok;
    logic accept;
    logic rsp;
    logic rsp_keep;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    logic byp;

    function automatic logic [AW-1:0] aq_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
        return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
    endfunction

    // Credits are computed from registered counts only, so a pop or response
    // frees a slot for the following cycle rather than combinationally.
    assign credit_ok = (outstanding < OW'(MAX_OUTSTANDING)) &&
                       ((SW'(outstanding) + SW'(fifo_count)) < SW'(FIFO_DEPTH));

    // reset_n gating keeps the request quiet while reset is held.
    assign mem_req_valid = reset_n && !flush && credit_ok;
    assign accept        = mem_req_valid && mem_req_ready;
    assign pc_count      = accept;
    assign mem_req_addr  = pc;

    // A stray response with nothing in flight is ignored rather than
    // corrupting the counters and the address queue.
    assign rsp        = mem_rsp_valid && (outstanding != '0);
    assign rsp_keep   = rsp && (discard == '0) && !flush;
    assign fifo_empty = (fifo_count == '0);
    assign aq_head    = aq_mem[aq_rd];

    always_comb begin
        byp       = 1'b0;
        fifo_push = rsp_keep;
`ifdef INSTRUCTION_FETCH_BYPASS_EN
        byp       = rsp_keep && fifo_empty;
        fifo_push = rsp_keep && !(byp && out_ready);
`endif
        out_valid = !fifo_empty || byp;
        out_instr = byp ? mem_rsp_data : fifo_instr[f_rd];
        out_pc    = byp ? aq_head      : fifo_pc[f_rd];
        fifo_pop  = !fifo_empty && out_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            discard     <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            if (accept && !rsp) begin
                outstanding <= outstanding + OW'(1);
            end else if (!accept && rsp) begin
                outstanding <= outstanding - OW'(1);
            end

            // On a redirect every read still in flight after this edge is
            // stale; that already covers any earlier pending discards.
            if (flush) begin
                discard <= outstanding + OW'(accept) - OW'(rsp);
            end else if (rsp && (discard != '0)) begin
                discard <= discard - OW'(1);
            end

            if (accept) begin
                aq_wr <= aq_inc(aq_wr);
            end
            // Dropped responses still pop so the queue stays aligned.
            if (rsp) begin
                aq_rd <= aq_inc(aq_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            aq_mem[aq_wr] <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
            f_wr       <= '0;
            f_rd       <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            f_wr       <= '0;
            f_rd       <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                fifo_instr[f_wr] <= mem_rsp_data;
                fifo_pc[f_wr]    <= aq_head;
                f_wr             <= f_inc(f_wr);
            end
            if (fifo_pop) begin
                f_rd <= f_inc(f_rd);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!fifo_push && fifo_pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && mem_rsp_valid) begin
            assert (outstanding != '0)
            else $error("instruction_fetch: response with no outstanding read");
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic        pc_count;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic [31:0] flush_target;
    logic        mem_auto;
    logic [31:0] q[$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc           (pc),
        .pc_count     (pc_count),
        .flush        (flush),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc)
    );

    function automatic logic [31:0] ins(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic creq(input string tag, input logic v, input logic [31:0] a, input logic c);
        chk1({tag, ".req_valid"}, mem_req_valid, v);
        if (v) chk({tag, ".req_addr"}, mem_req_addr, a);
        chk1({tag, ".pc_count"}, pc_count, c);
    endtask

    task automatic cout(input string tag, input logic v, input logic [31:0] p);
        chk1({tag, ".out_valid"}, out_valid, v);
        if (v) begin
            chk({tag, ".out_pc"}, out_pc, p);
            chk({tag, ".out_instr"}, out_instr, ins(p));
        end
    endtask

    task automatic look();
        #3;
    endtask

    // One clock: emulate the PC register and a 1-cycle in-order memory.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic        cnt;
        logic        f;
        acc = mem_req_valid & mem_req_ready;
        a   = mem_req_addr;
        cnt = pc_count;
        f   = flush;
        @(posedge clk);
        #1;
        if (f) pc = flush_target;
        else if (cnt) pc = pc + 32'd4;
        flush = 1'b0;
        if (acc) q.push_back(a);
        if (mem_auto && q.size() != 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = ins(q.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'd0;
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset_n       = 1'b0;
        q.delete();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        flush         = 1'b0;
        pc            = start_pc;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b0;
        pc            = 32'd0;
        flush         = 1'b0;
        flush_target  = 32'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        out_ready     = 1'b0;
        mem_auto      = 1'b0;

        @(posedge clk);
        #1;
        look();
        chk1("rst.out_valid", out_valid, 1'b0);
        chk1("rst.req_valid", mem_req_valid, 1'b0);
        chk1("rst.pc_count", pc_count, 1'b0);
        chk("rst.out_instr", out_instr, 32'd0);
        chk("rst.out_pc", out_pc, 32'd0);

        // Straight-line fetch from 0x0
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        mem_auto      = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        look(); creq("t1a", 1, 32'h0, 1); cout("t1a", 0, 0); tick();
        look(); creq("t1b", 1, 32'h4, 1); cout("t1b", 0, 0); tick();
        look(); creq("t1c", 0, 0, 0);     cout("t1c", 1, 32'h0); tick();
        look(); creq("t1d", 1, 32'h8, 1); cout("t1d", 1, 32'h4); tick();
        look(); creq("t1e", 1, 32'hC, 1); cout("t1e", 0, 0); tick();
        look(); cout("t1f", 1, 32'h8); tick();
        look(); cout("t1g", 1, 32'hC); tick();

        // Back-pressure from decode
        do_reset(32'h200);
        out_ready = 1'b0;
        look(); creq("t2a", 1, 32'h200, 1); cout("t2a", 0, 0); tick();
        look(); creq("t2b", 1, 32'h204, 1); tick();
        look(); creq("t2c", 0, 0, 0); cout("t2c", 1, 32'h200); tick();
        look(); creq("t2d", 0, 0, 0); cout("t2d", 1, 32'h200); tick();
        out_ready = 1'b1;
        look(); creq("t2e", 0, 0, 0); cout("t2e", 1, 32'h200); tick();
        look(); creq("t2f", 1, 32'h208, 1); cout("t2f", 1, 32'h204); tick();
        look(); cout("t2g", 0, 0); tick();
        look(); cout("t2h", 1, 32'h208); tick();

        // Flush with two reads in flight
        mem_auto = 1'b0;
        do_reset(32'h10);
        look(); creq("t3a", 1, 32'h10, 1); tick();
        look(); creq("t3b", 1, 32'h14, 1); tick();
        flush        = 1'b1;
        flush_target = 32'h100;
        mem_auto     = 1'b1;
        look(); creq("t3c", 0, 0, 0); cout("t3c", 0, 0); tick();
        look(); creq("t3d", 0, 0, 0); cout("t3d", 0, 0); tick();
        look(); creq("t3e", 1, 32'h100, 1); cout("t3e", 0, 0); tick();
        look(); creq("t3f", 1, 32'h104, 1); cout("t3f", 0, 0); tick();

        // Flush together with a response and a decode pop
        flush        = 1'b1;
        flush_target = 32'h300;
        look();
        chk1("t4g.rsp_valid", mem_rsp_valid, 1'b1);
        cout("t4g", 1, 32'h100); creq("t4g", 0, 0, 0); tick();
        look(); creq("t4h", 1, 32'h300, 1); cout("t4h", 0, 0); tick();
        look(); creq("t4i", 1, 32'h304, 1); cout("t4i", 0, 0); tick();
        look(); cout("t4j", 1, 32'h300); tick();

        // Memory ready toggling
        do_reset(32'h400);
        mem_req_ready = 1'b1; look(); creq("t5a", 1, 32'h400, 1); tick();
        mem_req_ready = 1'b0; look(); creq("t5b", 1, 32'h404, 0); cout("t5b", 0, 0); tick();
        mem_req_ready = 1'b1; look(); creq("t5c", 1, 32'h404, 1); cout("t5c", 1, 32'h400); tick();
        mem_req_ready = 1'b0; look(); creq("t5d", 1, 32'h408, 0); cout("t5d", 0, 0); tick();
        mem_req_ready = 1'b1; look(); creq("t5e", 1, 32'h408, 1); cout("t5e", 1, 32'h404); tick();
        mem_req_ready = 1'b0; look(); creq("t5f", 1, 32'h40C, 0); cout("t5f", 0, 0); tick();
        mem_req_ready = 1'b1;
        mem_auto      = 1'b0;
        look(); creq("t5g", 1, 32'h40C, 1); cout("t5g", 1, 32'h408); tick();

        // Asynchronous reset with two reads outstanding
        look(); creq("t6h", 1, 32'h410, 1); cout("t6h", 0, 0); tick();
        look(); creq("t6i", 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk1("t6rst.out_valid", out_valid, 1'b0);
        chk1("t6rst.req_valid", mem_req_valid, 1'b0);
        chk1("t6rst.pc_count", pc_count, 1'b0);
        chk("t6rst.out_instr", out_instr, 32'd0);
        chk("t6rst.out_pc", out_pc, 32'd0);
        q.delete();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        pc            = 32'h600;
        mem_auto      = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        look(); creq("t6a", 1, 32'h600, 1); cout("t6a", 0, 0); tick();
        look(); creq("t6b", 1, 32'h604, 1); cout("t6b", 0, 0); tick();
        look(); cout("t6c", 1, 32'h600); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
